level_round_tracker: RTL and testbench



---
 rtl/game_pkg.sv | 19 +
 rtl/sec_prescaler.sv | 28 ++
 rtl/level_round_tracker.sv | 104 ++++++++++
 tb/tb_level_round_tracker.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared widths, round-state encoding and helpers for the level game
package game_pkg;

  localparam int COUNT_W = 5;
  localparam int SEC_W   = 6;
  localparam logic [COUNT_W-1:0] MAX_COUNT = 5'd31;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } round_state_t;

  function automatic logic [COUNT_W-1:0] abs_diff(input logic [COUNT_W-1:0] a,
                                                  input logic [COUNT_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/sec_prescaler.sv
// rtl/sec_prescaler.sv - divides the system clock down to a one-cycle pulse per second
module sec_prescaler #(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] cnt;

  // Tick is decoded from the count so the wrap and the second-boundary coincide.
  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/level_round_tracker.sv
// rtl/level_round_tracker.sv - runs one timed round of button presses and reports the miss distance
module level_round_tracker
  import game_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int ROUND_SECONDS = 10
) (
  input  logic               Clk100M,
  input  logic               Reset,
  input  logic               startLevel,
  input  logic [COUNT_W-1:0] target,
  input  logic               userPulse,
  input  logic               submit,
  output logic               levelComplete,
  output logic [COUNT_W-1:0] difference,
  output logic [COUNT_W-1:0] userCount,
  output logic [SEC_W-1:0]   secondsLeft,
  output logic               busy
);

  localparam logic [SEC_W-1:0] ROUND_SEC = SEC_W'(ROUND_SECONDS);

  round_state_t       state;
  logic [COUNT_W-1:0] target_reg;
  logic [COUNT_W-1:0] count_next;
  logic               tick;
  logic               timeout;
  logic               end_round;
  logic               accept_start;

  assign accept_start = (state == IDLE) && startLevel;

  sec_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clk   (Clk100M),
    .reset (Reset),
    .clear (accept_start),
    .enable(state == RUN),
    .tick  (tick)
  );

  // A press in the closing cycle still counts toward the reported difference.
  always_comb begin
    count_next = userCount;
    if ((state == RUN) && userPulse && (userCount != MAX_COUNT)) begin
      count_next = userCount + COUNT_W'(1);
    end
  end

  assign timeout   = tick && (secondsLeft == SEC_W'(1));
  assign end_round = (state == RUN) && (submit || timeout);

  always_ff @(posedge Clk100M) begin
    if (Reset) begin
      state         <= IDLE;
      target_reg    <= '0;
      levelComplete <= 1'b0;
      difference    <= '0;
      userCount     <= '0;
      secondsLeft   <= '0;
      busy          <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          levelComplete <= 1'b0;
          if (startLevel) begin
            target_reg  <= target;
            userCount   <= '0;
            secondsLeft <= ROUND_SEC;
            difference  <= '0;
            busy        <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          userCount <= count_next;
          if (end_round) begin
            difference    <= abs_diff(target_reg, count_next);
            levelComplete <= 1'b1;
            busy          <= 1'b0;
            state         <= DONE;
            // A submit coinciding with the final wrap keeps the displayed second.
            if (!submit) begin
              secondsLeft <= '0;
            end
          end else if (tick) begin
            secondsLeft <= secondsLeft - SEC_W'(1);
          end
        end
        DONE: begin
          levelComplete <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          levelComplete <= 1'b0;
          busy          <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_level_round_tracker.sv
// tb/tb_level_round_tracker.sv - scoreboard bench for level_round_tracker with a round-level model
module tb_level_round_tracker;

  logic       clk;
  logic       rst;
  logic       start_s  [2];
  logic [4:0] tgt_s    [2];
  logic       pulse_s  [2];
  logic       sub_s    [2];
  logic       lc_s     [2];
  logic [4:0] diff_s   [2];
  logic [4:0] cnt_s    [2];
  logic [5:0] secs_s   [2];
  logic       busy_s   [2];

  typedef struct {
    int cyc;
    int diff;
    int cnt;
    int secs;
  } exp_t;

  exp_t sb [2][$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   p_arr [1:64];
  bit   s_arr [1:64];

  level_round_tracker #(.TICKS_PER_SEC(4), .ROUND_SECONDS(3)) dut (
    .Clk100M(clk), .Reset(rst), .startLevel(start_s[0]), .target(tgt_s[0]),
    .userPulse(pulse_s[0]), .submit(sub_s[0]), .levelComplete(lc_s[0]),
    .difference(diff_s[0]), .userCount(cnt_s[0]), .secondsLeft(secs_s[0]), .busy(busy_s[0])
  );

  // Longer round so the press counter can be driven past saturation.
  level_round_tracker #(.TICKS_PER_SEC(16), .ROUND_SECONDS(3)) dut_long (
    .Clk100M(clk), .Reset(rst), .startLevel(start_s[1]), .target(tgt_s[1]),
    .userPulse(pulse_s[1]), .submit(sub_s[1]), .levelComplete(lc_s[1]),
    .difference(diff_s[1]), .userCount(cnt_s[1]), .secondsLeft(secs_s[1]), .busy(busy_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (lc_s[i] === 1'b1) begin
        if (sb[i].size() == 0) begin
          chk($sformatf("unexpected_levelComplete_dut%0d", i), 1, 0);
        end else begin
          exp_t e;
          e = sb[i].pop_front();
          chk($sformatf("lc_cycle_dut%0d", i), cyc, e.cyc);
          chk($sformatf("difference_dut%0d", i), {27'd0, diff_s[i]}, e.diff);
          chk($sformatf("userCount_end_dut%0d", i), {27'd0, cnt_s[i]}, e.cnt);
          chk($sformatf("secondsLeft_end_dut%0d", i), {26'd0, secs_s[i]}, e.secs);
          chk($sformatf("busy_in_done_dut%0d", i), {31'd0, busy_s[i]}, 0);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; tgt_s[i] = '0; pulse_s[i] = 1'b0; sub_s[i] = 1'b0;
    end
  endtask

  task automatic clr_plan();
    for (int c = 1; c <= 64; c++) begin
      p_arr[c] = 1'b0;
      s_arr[c] = 1'b0;
    end
  endtask

  task automatic chk_zero(input int d);
    chk("reset_levelComplete", {31'd0, lc_s[d]}, 0);
    chk("reset_difference", {27'd0, diff_s[d]}, 0);
    chk("reset_userCount", {27'd0, cnt_s[d]}, 0);
    chk("reset_secondsLeft", {26'd0, secs_s[d]}, 0);
    chk("reset_busy", {31'd0, busy_s[d]}, 0);
  endtask

  // Round model: the first submit (or the last tick of the round) ends it; presses up to and
  // including that cycle count, capped at 31; the clock shows whole seconds not yet elapsed.
  task automatic play_round(input int d, input int tgt, input bit poke);
    int tps, rs, len, e, pres, live, secs, diff, t0;
    bit subm;
    exp_t ex;
    tps = (d == 0) ? 4 : 16;
    rs = 3;
    len = tps * rs;
    e = len;
    subm = 1'b0;
    for (int c = 1; c <= len; c++) begin
      if (s_arr[c] && !subm) begin
        e = c;
        subm = 1'b1;
      end
    end
    pres = 0;
    for (int c = 1; c <= e; c++) pres += p_arr[c];
    if (pres > 31) pres = 31;
    secs = subm ? rs - (e - 1) / tps : 0;
    diff = (tgt >= pres) ? tgt - pres : pres - tgt;

    step();
    t0 = cyc;
    start_s[d] = 1'b1;
    tgt_s[d] = 5'(tgt);
    ex.cyc = t0 + e + 1; ex.diff = diff; ex.cnt = pres; ex.secs = secs;
    sb[d].push_back(ex);
    live = 0;
    for (int c = 1; c <= e; c++) begin
      step();
      chk("busy_running", {31'd0, busy_s[d]}, 1);
      chk("secondsLeft_live", {26'd0, secs_s[d]}, rs - (c - 1) / tps);
      chk("userCount_live", {27'd0, cnt_s[d]}, (live > 31) ? 31 : live);
      live += p_arr[c];
      start_s[d] = poke && (c == 2);
      tgt_s[d] = 5'($urandom_range(0, 31));
      pulse_s[d] = p_arr[c];
      sub_s[d] = s_arr[c];
    end
    step();
    start_s[d] = poke;
    tgt_s[d] = 5'($urandom_range(0, 31));
    pulse_s[d] = 1'b0;
    sub_s[d] = 1'b0;
    step();
    start_s[d] = 1'b0;
    chk("busy_after_round", {31'd0, busy_s[d]}, 0);
    chk("difference_held", {27'd0, diff_s[d]}, diff);
    chk("userCount_held", {27'd0, cnt_s[d]}, pres);
    step();
  endtask

  initial begin
    rst = 1'b1;
    idle_all();

    // Reset with random input activity.
    for (int k = 0; k < 2; k++) begin
      step();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
        start_s[i] = 1'($urandom); tgt_s[i] = 5'($urandom);
        pulse_s[i] = 1'($urandom); sub_s[i] = 1'($urandom);
      end
    end
    step();
    rst = 1'b0;
    idle_all();
    chk_zero(0);
    chk_zero(1);
    repeat (20) step();

    // Timeout with exact match.
    clr_plan();
    for (int c = 1; c <= 7; c++) p_arr[c] = 1'b1;
    play_round(0, 7, 1'b0);

    // Early submit.
    clr_plan();
    p_arr[2] = 1'b1; p_arr[3] = 1'b1; s_arr[6] = 1'b1;
    play_round(0, 5, 1'b0);

    // Saturation on the long-round instance.
    clr_plan();
    for (int c = 1; c <= 40; c++) p_arr[c] = 1'b1;
    s_arr[41] = 1'b1;
    play_round(1, 0, 1'b0);

    // Press coinciding with submit, plus ignored startLevel in RUN and DONE.
    clr_plan();
    p_arr[2] = 1'b1; p_arr[4] = 1'b1; p_arr[7] = 1'b1; s_arr[7] = 1'b1;
    play_round(0, 3, 1'b1);

    // Submit on the final wrap cycle holds the last second.
    clr_plan();
    p_arr[5] = 1'b1; s_arr[12] = 1'b1;
    play_round(0, 9, 1'b0);

    // Reset mid-round aborts silently.
    clr_plan();
    step();
    start_s[0] = 1'b1; tgt_s[0] = 5'd20;
    for (int c = 1; c <= 5; c++) begin
      step();
      start_s[0] = 1'b0;
      pulse_s[0] = 1'b1;
      rst = (c == 5);
    end
    step();
    rst = 1'b0;
    idle_all();
    chk_zero(0);
    repeat (4) step();
    clr_plan();
    p_arr[3] = 1'b1; s_arr[4] = 1'b1;
    play_round(0, 4, 1'b0);

    // Random rounds.
    for (int r = 0; r < 10; r++) begin
      clr_plan();
      for (int c = 1; c <= 12; c++) p_arr[c] = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 1) == 1) s_arr[$urandom_range(1, 12)] = 1'b1;
      play_round(0, int'($urandom_range(0, 31)), 1'($urandom));
    end

    repeat (5) step();
    chk("pending_expectations_dut0", sb[0].size(), 0);
    chk("pending_expectations_dut1", sb[1].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
